// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache.
// Holds the controller state encoding, the word/block/address widths and a
// helper that picks one word out of a two-word block.
package cache_pkg;

    localparam int unsigned WordW  = 10;
    localparam int unsigned BlockW = 20;
    localparam int unsigned AddrW  = 10;

    typedef enum logic [1:0] {
        StIdle,
        StMemReq,
        StMemWait,
        StResp
    } cache_state_e;

    // Block layout is {odd word, even word}; the offset bit selects the half.
    function automatic logic [WordW-1:0] sel_word(input logic [BlockW-1:0] blk,
                                                  input logic              off);
        return off ? blk[BlockW-1:WordW] : blk[WordW-1:0];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset (clears valid bits)
//   lk_idx_i, lk_tag_i       combinational lookup; lk_hit_o / lk_block_o respond
//   fill_*                   synchronous whole-line fill (sets valid and tag)
//   upd_*                    synchronous single-word update of a resident line
module cache_line_array
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    localparam int unsigned IdxW = $clog2(LINES),
    localparam int unsigned TagW = AddrW - 1 - IdxW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IdxW-1:0]   lk_idx_i,
    input  logic [TagW-1:0]   lk_tag_i,
    output logic              lk_hit_o,
    output logic [BlockW-1:0] lk_block_o,
    input  logic              fill_en_i,
    input  logic [IdxW-1:0]   fill_idx_i,
    input  logic [TagW-1:0]   fill_tag_i,
    input  logic [BlockW-1:0] fill_block_i,
    input  logic              upd_en_i,
    input  logic [IdxW-1:0]   upd_idx_i,
    input  logic              upd_off_i,
    input  logic [WordW-1:0]  upd_word_i
);

    logic [LINES-1:0]  valid_q;
    logic [TagW-1:0]   tag_q  [LINES];
    logic [BlockW-1:0] data_q [LINES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only trusted when valid is set.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_block_i;
        end else if (upd_en_i) begin
            if (upd_off_i) begin
                data_q[upd_idx_i][BlockW-1:WordW] <= upd_word_i;
            end else begin
                data_q[upd_idx_i][WordW-1:0] <= upd_word_i;
            end
        end
    end

    always_comb begin
        lk_hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
        lk_block_o = data_q[lk_idx_i];
    end

endmodule

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with 2-word blocks.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata              CPU request, sampled only while cpu_ready=1
//   cpu_ready, cpu_ack, cpu_rdata      CPU handshake; rdata valid with the ack pulse
//   mem_req/we/addr, mem_data, mem_ready  memory side; mem_data is {odd, even}
//   hit_count, miss_count              read statistics
// Optional feature: define CACHE_STATS_EN to build saturating read hit/miss
// counters; otherwise both counter outputs are tied to zero.
module direct_mapped_cache
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AddrW-1:0]  cpu_addr,
    input  logic [WordW-1:0]  cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_ack,
    output logic [WordW-1:0]  cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AddrW-1:0]  mem_addr,
    inout  wire  [BlockW-1:0] mem_data,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = AddrW - 1 - IdxW;

    cache_state_e      state_q, state_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic              we_q, we_d;
    logic [WordW-1:0]  wdata_q, wdata_d;
    logic              hit_q, hit_d;
    logic              seen_low_q, seen_low_d;
    logic [WordW-1:0]  rdata_q, rdata_d;
    logic [AddrW-1:0]  mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;

    logic              lk_hit;
    logic [BlockW-1:0] lk_block;
    logic              fill_en;
    logic              upd_en;

    cache_line_array #(
        .LINES (LINES)
    ) u_lines (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lk_idx_i     (cpu_addr[IdxW:1]),
        .lk_tag_i     (cpu_addr[AddrW-1:IdxW+1]),
        .lk_hit_o     (lk_hit),
        .lk_block_o   (lk_block),
        .fill_en_i    (fill_en),
        .fill_idx_i   (addr_q[IdxW:1]),
        .fill_tag_i   (addr_q[AddrW-1:IdxW+1]),
        .fill_block_i (mem_data),
        .upd_en_i     (upd_en),
        .upd_idx_i    (addr_q[IdxW:1]),
        .upd_off_i    (addr_q[0]),
        .upd_word_i   (wdata_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            hit_q      <= 1'b0;
            seen_low_q <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            hit_q      <= hit_d;
            seen_low_q <= seen_low_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        seen_low_d = seen_low_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        fill_en    = 1'b0;
        upd_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d     = cpu_addr;
                    we_d       = cpu_we;
                    wdata_d    = cpu_wdata;
                    hit_d      = lk_hit;
                    seen_low_d = 1'b0;
                    if (!cpu_we && lk_hit) begin
                        rdata_d = sel_word(lk_block, cpu_addr[0]);
                        state_d = StResp;
                    end else begin
                        // Reads fetch the whole block, so align to the even word.
                        mem_addr_d = cpu_we ? cpu_addr : {cpu_addr[AddrW-1:1], 1'b0};
                        mem_we_d   = cpu_we;
                        state_d    = StMemReq;
                    end
                end
            end
            StMemReq: begin
                // Hold off until memory is idle (also covers post-reset leftovers).
                if (mem_ready) begin
                    state_d = StMemWait;
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = StResp;
                    if (!we_q) begin
                        fill_en = 1'b1;
                        rdata_d = sel_word(mem_data, addr_q[0]);
                    end else if (hit_q) begin
                        upd_en = 1'b1;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cpu_ready = (state_q == StIdle);
        cpu_ack   = (state_q == StResp);
        cpu_rdata = rdata_q;
        mem_req   = (state_q == StMemReq) && mem_ready;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
    end

    // Drive the bus only in the single write-request cycle.
    assign mem_data = (mem_req && mem_we_q) ? {wdata_q, wdata_q} : {BlockW{1'bz}};

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StResp && !we_q) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Directed self-checking bench for direct_mapped_cache with a 3-cycle
// handshake memory model (mem_ready low for 2 cycles after each mem_req).
module tb_direct_mapped_cache;

`ifdef CACHE_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr, cpu_wdata;
    logic        cpu_ready, cpu_ack;
    logic [9:0]  cpu_rdata;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    wire  [19:0] mem_data;
    logic        mem_ready = 1'b1;
    logic [15:0] hit_count, miss_count;

    // Memory model driver, plus a zero-driving probe used to show the DUT is off the bus.
    logic        mdrv_en  = 1'b0;
    logic [19:0] mdrv_val = 20'h0;
    logic        probe_en = 1'b0;
    assign mem_data = mdrv_en ? mdrv_val : (probe_en ? 20'h0 : 20'bz);

    always #5 clk = ~clk;

    direct_mapped_cache #(
        .LINES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Memory model
    logic [9:0] mem [1024];
    int         mem_cnt   = 0;
    int         req_total = 0;
    logic       mw_we     = 1'b0;
    logic [9:0] mw_addr   = '0;

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            req_total <= req_total + 1;
            mw_we     <= mem_we;
            mw_addr   <= mem_addr;
            if (mem_we) mem[mem_addr] <= mem_data[9:0];
            mem_ready <= 1'b0;
            mem_cnt   <= 2;
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                mem_ready <= 1'b1;
                if (!mw_we) begin
                    mdrv_en  <= 1'b1;
                    mdrv_val <= {mem[{mw_addr[9:1], 1'b1}], mem[{mw_addr[9:1], 1'b0}]};
                end
            end
        end else begin
            mdrv_en <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ec(input int n);
        return Stats ? n : 0;
    endfunction

    // One CPU access; inputs are scrambled after acceptance to show they are latched.
    task automatic access(input logic we, input logic [9:0] addr, input logic [9:0] wd,
                          output logic [9:0] rd, output int lat, output int nreq,
                          output logic [9:0] s_addr, output logic s_we,
                          output logic [19:0] s_data);
        int guard;
        int start;
        logic acked;
        guard = 0;
        while (!cpu_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start     = req_total;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_we    = ~we;
        cpu_addr  = ~addr;
        cpu_wdata = ~wd;
        lat    = 0;
        acked  = 1'b0;
        rd     = 'x;
        s_addr = 'x;
        s_we   = 1'bx;
        s_data = 'x;
        while (lat < 50 && !acked) begin
            @(negedge clk);
            lat++;
            if (mem_req) begin
                s_addr = mem_addr;
                s_we   = mem_we;
                s_data = mem_data;
            end
            if (cpu_ack) begin
                rd    = cpu_rdata;
                acked = 1'b1;
            end
        end
        cpu_req = 1'b0;
        nreq    = req_total - start;
        chk("ack_seen", {31'd0, acked}, 32'd1);
    endtask

    logic [9:0]  rd, s_addr;
    logic        s_we;
    logic [19:0] s_data;
    int          lat, nreq, guard, acks;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10] = 10'd5;
        mem[11] = 10'd10;

        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        probe_en  = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {22'd0, cpu_rdata}, 32'd0);
        chk("rst_hits", {16'd0, hit_count}, 32'd0);
        chk("rst_misses", {16'd0, miss_count}, 32'd0);
        chk("rst_bus_z", {12'd0, mem_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        probe_en = 1'b0;

        // Cold read miss on word 10
        access(1'b0, 10'd10, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd10_data", {22'd0, rd}, 32'd5);
        chk("rd10_nreq", nreq, 32'd1);
        chk("rd10_maddr", {22'd0, s_addr}, 32'd10);
        chk("rd10_mwe", {31'd0, s_we}, 32'd0);
        chk("rd10_lat", lat, 32'd5);
        @(negedge clk);
        chk("rd10_miss_cnt", {16'd0, miss_count}, ec(1));
        chk("rd10_hit_cnt", {16'd0, hit_count}, ec(0));

        // Read hit on word 11 of the same block
        access(1'b0, 10'd11, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd11_data", {22'd0, rd}, 32'd10);
        chk("rd11_lat", lat, 32'd1);
        chk("rd11_nreq", nreq, 32'd0);
        @(negedge clk);
        chk("rd11_hit_cnt", {16'd0, hit_count}, ec(1));

        // Write hit 11=7, then read it back from the cache
        access(1'b1, 10'd11, 10'd7, rd, lat, nreq, s_addr, s_we, s_data);
        chk("wr11_nreq", nreq, 32'd1);
        chk("wr11_maddr", {22'd0, s_addr}, 32'd11);
        chk("wr11_mwe", {31'd0, s_we}, 32'd1);
        chk("wr11_mdata", {12'd0, s_data}, 32'h01C07);
        chk("wr11_mem", {22'd0, mem[11]}, 32'd7);
        access(1'b0, 10'd11, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd11b_data", {22'd0, rd}, 32'd7);
        chk("rd11b_lat", lat, 32'd1);
        chk("rd11b_nreq", nreq, 32'd0);

        // Conflict: 26 shares the index of 10 with a different tag
        access(1'b0, 10'd26, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd26_data", {22'd0, rd}, 32'd0);
        chk("rd26_nreq", nreq, 32'd1);
        chk("rd26_maddr", {22'd0, s_addr}, 32'd26);
        access(1'b0, 10'd10, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd10b_data", {22'd0, rd}, 32'd5);
        chk("rd10b_nreq", nreq, 32'd1);

        // Write miss does not allocate
        access(1'b1, 10'd40, 10'd3, rd, lat, nreq, s_addr, s_we, s_data);
        chk("wr40_nreq", nreq, 32'd1);
        chk("wr40_maddr", {22'd0, s_addr}, 32'd40);
        chk("wr40_mdata", {12'd0, s_data}, 32'h00C03);
        access(1'b0, 10'd40, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("rd40_data", {22'd0, rd}, 32'd3);
        chk("rd40_nreq", nreq, 32'd1);
        chk("rd40_maddr", {22'd0, s_addr}, 32'd40);
        @(negedge clk);
        chk("seq_hit_cnt", {16'd0, hit_count}, ec(2));
        chk("seq_miss_cnt", {16'd0, miss_count}, ec(4));

        // Reset during MEM_WAIT of a read miss
        guard = 0;
        while (!cpu_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'd100;
        cpu_wdata = 10'h3FF;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        guard   = 0;
        while (!mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_req_seen", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        probe_en = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_mid_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mid_rdata", {22'd0, cpu_rdata}, 32'd0);
        chk("rst_mid_bus_z", {12'd0, mem_data}, 32'd0);
        chk("rst_mid_misses", {16'd0, miss_count}, 32'd0);
        @(negedge clk);
        probe_en = 1'b0;
        rst_n    = 1'b1;
        acks     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        chk("rst_mid_no_ack", acks, 32'd0);
        access(1'b0, 10'd10, 10'd0, rd, lat, nreq, s_addr, s_we, s_data);
        chk("post_rst_rd10_data", {22'd0, rd}, 32'd5);
        chk("post_rst_rd10_nreq", nreq, 32'd1);
        chk("post_rst_rd10_maddr", {22'd0, s_addr}, 32'd10);
        @(negedge clk);
        chk("post_rst_miss_cnt", {16'd0, miss_count}, ec(1));
        chk("post_rst_hit_cnt", {16'd0, hit_count}, ec(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter LINES, default 8, number of cache lines (power of two, 2..64); each line holds one 2-word (20-bit) block.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, sampled only while cpu_ready=1
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  10  word address
- cpu_wdata  in  10  write data
- cpu_ready  out  1  cache can accept a request
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  10  read data, valid in the cpu_ack cycle
- mem_req  out  1  memory request, single-cycle pulse
- mem_we  out  1  memory write enable
- mem_addr  out  10  memory word address
- mem_data  inout  20  memory block bus {odd word, even word}
- mem_ready  in  1  memory idle/done
- hit_count  out  16  read-hit counter (see Configuration)
- miss_count  out  16  read-miss counter (see Configuration)

Function
REQ-003 SHALL decode cpu_addr as offset=addr[0], index=addr[log2(LINES):1], tag=remaining upper bits.
REQ-004 SHALL hold per line: valid bit, tag, 20-bit block.
REQ-005 SHALL use states IDLE, MEM_REQ, MEM_WAIT, RESP; cpu_ready=1 only in IDLE.
REQ-006 Read hit (IDLE, cpu_req, valid and tag match): cpu_ack and cpu_rdata=selected word at cycle N+1; no memory traffic.
REQ-007 Read miss: IDLE->MEM_REQ; mem_req=1, mem_we=0, mem_addr={addr[9:1],0} for one cycle; MEM_WAIT until mem_ready has been seen 0 then 1; in that mem_ready=1 cycle sample mem_data into the line, set valid and tag; RESP asserts cpu_ack with the requested word, then IDLE.
REQ-008 Write (hit or miss): write-through, no-write-allocate; on hit update the addressed word in the line; issue mem_req with mem_we=1, mem_addr=cpu_addr, mem_data driven {cpu_wdata,cpu_wdata} in the mem_req cycle only; cpu_ack after mem_ready returns 1 as in REQ-007.
REQ-009 mem_data SHALL be high-Z except during the mem_req=1, mem_we=1 cycle.
REQ-010 mem_addr and mem_we SHALL remain stable from the mem_req cycle until the mem_ready=1 sampling cycle.
REQ-011 mem_req SHALL be issued only when mem_ready=1 and at least one cycle after the previous transaction's mem_ready=1 sampling cycle.
REQ-012 CPU request inputs SHALL be latched at acceptance; changes while cpu_ready=0 are ignored.
REQ-013 A miss on a valid line with a different tag SHALL overwrite it; no write-back is needed.

Reset
REQ-014 rst_n=0 SHALL immediately force: state IDLE, all valid bits 0, mem_req 0, mem_we 0, mem_addr 0, mem_data high-Z, cpu_ready 1, cpu_ack 0, cpu_rdata 0, counters 0.
REQ-015 Reset mid-transaction SHALL abandon it without ack; the first post-reset mem_req SHALL wait for mem_ready=1 (REQ-011).

Configuration
REQ-016 With CACHE_STATS_EN defined: hit_count/miss_count increment on each read hit/miss at the ack cycle, saturating at 16'hFFFF; writes not counted.
REQ-017 Without CACHE_STATS_EN: hit_count and miss_count are constant 0 and no counter registers exist.

Structure
REQ-018 Shared package cache_pkg SHALL hold the state encoding, word width (10), block width (20), and address width (10).
REQ-019 Valid/tag/data storage SHALL be sub-module cache_line_array (LINES parameter, combinational lookup, synchronous line fill and word update, asynchronous valid clear).

Verification
REQ-020 Bench SHALL model the memory with 3-cycle handshake (mem_ready low 2 cycles after mem_req) and preload word 10=5, word 11=10, and cover:
- read addr 10 after reset -> one mem_req, mem_addr=10, cpu_rdata=5 with cpu_ack; miss_count=1
- then read addr 11 -> cpu_ack at N+1, cpu_rdata=10, no mem_req; hit_count=1
- write addr 11=7 then read addr 11 -> mem write to 11 with mem_data={7,7}; read hit returns 7
- read addr 26 (same index as 10, different tag) then read addr 10 -> both miss; returns 0 then 5
- write addr 40=3 (miss) then read addr 40 -> write does not allocate; read misses and returns 3
- rst_n low during MEM_WAIT -> no cpu_ack, cpu_ready=1, mem_data high-Z; next read 10 misses and returns 5
